// File: rtl/fod_spi_regfile.sv
// rtl/fod_spi_regfile.sv - SPI-slave double-buffered register file feeding the FOD controller
// Optional per-frame odd parity bit is enabled by defining FOD_SPI_PARITY_EN.
module fod_spi_regfile #(
    parameter int AW = 7,
    parameter int DW = 8,
    parameter int NREG = 16,
    parameter logic [NREG*DW-1:0] RST_VAL = {NREG*DW{1'b0}}
) (
    input  logic               CLK,
    input  logic               NARST,
    input  logic               SCK,
    input  logic               CSN,
    input  logic               MOSI,
    output logic               MISO,
    output logic               MISO_OE,
    input  logic               EXT_APPLY,
    output logic [NREG*DW-1:0] REG_Q,
    output logic               UPDATE_PULSE,
    output logic               FRAME_ERR
);
`ifdef FOD_SPI_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int FRAME_W = 1 + AW + DW + PW;
    localparam int CW = $clog2(FRAME_W + 2);
    localparam logic [CW-1:0] CNT_ADDR = CW'(1 + AW);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_W);
    localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_W + 1);
    // Slot 0 of the shadow holds the control scratch bits; its APPLY bit is never stored.
    localparam logic [NREG*DW-1:0] SHADOW_RST = RST_VAL & ~(NREG*DW)'(1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             sck_q, csn_q;
    logic [1:0]             mosi_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [FRAME_W-1:0]     shift_q, shift_d;
    logic [DW-1:0]          tx_q, tx_d;
    logic                   miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic [NREG*DW-1:0]     shadow_q, shadow_d;
    logic [NREG*DW-1:DW]    active_q, active_d;
    logic                   apply_pend_q, apply_pend_d;
    logic                   update_q, update_d, frame_err_q, frame_err_d;
    logic                   commit_apply, par_ok, f_rw, f_addr_ok;
    logic [AW-1:0]          f_addr;
    logic [DW-1:0]          f_data;
    logic                   sck_rise, sck_fall, csn_fall, csn_rise;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign csn_fall = ~csn_q[1] & csn_q[2];
    assign csn_rise = csn_q[1] & ~csn_q[2];

    assign f_rw      = shift_q[FRAME_W-1];
    assign f_addr    = shift_q[FRAME_W-2 -: AW];
    assign f_data    = shift_q[PW +: DW];
    assign f_addr_ok = ({1'b0, f_addr} < (AW+1)'(NREG));
`ifdef FOD_SPI_PARITY_EN
    assign par_ok = ^shift_q;
`else
    assign par_ok = 1'b1;
`endif

    function automatic logic [DW-1:0] read_val(input logic [AW-1:0] a,
                                               input logic [NREG*DW-1:0] sh);
        read_val = '0;
        for (int i = 0; i < NREG; i++)
            if (a == AW'(i)) read_val = sh[i*DW +: DW];
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        miso_d       = miso_q;
        miso_oe_d    = miso_oe_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        apply_pend_d = 1'b0;
        update_d     = 1'b0;
        frame_err_d  = 1'b0;
        commit_apply = 1'b0;
        // EXT_APPLY copies the shadow as it stood before any commit on this same edge.
        if (EXT_APPLY || apply_pend_q) begin
            active_d = shadow_q[NREG*DW-1:DW];
            update_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (csn_fall) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (csn_rise) begin
                    state_d   = S_IDLE;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    if (cnt_q != CNT_FULL) begin
                        frame_err_d = 1'b1;
                    end else if (f_rw) begin
                        if (!par_ok) begin
                            frame_err_d = 1'b1;
                        end else if (f_addr_ok) begin
                            for (int i = 0; i < NREG; i++)
                                if (f_addr == AW'(i)) shadow_d[i*DW +: DW] = f_data;
                            if (f_addr == '0) begin
                                shadow_d[0]  = 1'b0;
                                commit_apply = f_data[0];
                            end
                        end
                    end
                end else begin
                    if (sck_rise) begin
                        shift_d = {shift_q[FRAME_W-2:0], mosi_q[1]};
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
                        if (state_q == S_ADDR && cnt_d == CNT_ADDR) begin
                            state_d = S_DATA;
                            if (!shift_d[AW]) begin
                                tx_d      = read_val(shift_d[AW-1:0], shadow_q);
                                miso_oe_d = 1'b1;
                            end
                        end
                        if (state_q == S_DATA && cnt_d == CNT_FULL) state_d = S_DONE;
                    end
                    if (sck_fall && miso_oe_q) begin
                        miso_d = tx_q[DW-1];
                        tx_d   = {tx_q[DW-2:0], 1'b0};
                    end
                end
            end
        endcase
        // A simultaneous EXT_APPLY already covers an APPLY commit: one update only.
        if (commit_apply && !EXT_APPLY) apply_pend_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge NARST) begin
        if (!NARST) begin
            sck_q        <= 3'b000;
            csn_q        <= 3'b111;
            mosi_q       <= 2'b00;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            tx_q         <= '0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            shadow_q     <= SHADOW_RST;
            active_q     <= RST_VAL[NREG*DW-1:DW];
            apply_pend_q <= 1'b0;
            update_q     <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sck_q        <= {sck_q[1:0], SCK};
            csn_q        <= {csn_q[1:0], CSN};
            mosi_q       <= {mosi_q[0], MOSI};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            apply_pend_q <= apply_pend_d;
            update_q     <= update_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign REG_Q        = {active_q, shadow_q[DW-1:0]};
    assign MISO         = miso_q;
    assign MISO_OE      = miso_oe_q;
    assign UPDATE_PULSE = update_q;
    assign FRAME_ERR    = frame_err_q;
endmodule
